// File: rtl/pipe_hazard_spine_pkg.sv
// Shared types and helpers for the pipeline hazard spine: stage metadata,
// select-width computation and the register-match / availability predicates.
package pipe_pkg;

  localparam int REG_AW_MAX  = 8;
  localparam int SEL_REGFILE = 0;

  // rd is sized for the widest supported register file; narrower files zero-extend.
  typedef struct packed {
    logic                  v;
    logic [REG_AW_MAX-1:0] rd;
    logic                  wr;
    logic                  ld;
  } stage_meta_t;

  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  function automatic logic writes_reg(input stage_meta_t m, input logic [REG_AW_MAX-1:0] r);
    return m.v && m.wr && (m.rd == r) && (r != '0);
  endfunction

  function automatic logic result_avail(input stage_meta_t m, input int k, input int load_lat);
    return !m.ld || (k >= load_lat);
  endfunction

endpackage

// File: rtl/pipe_hazard_spine_if.sv
// Decode-side issue handshake, forwarding selects, writeback view and counters.
// Handshake: an instruction transfers on a cycle where in_valid && in_ready;
// in_ready never depends on itself and drops combinationally on flush, hazard or reset.
interface pipe_hazard_spine_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic [REG_AW-1:0] in_rd;
  logic              in_wr;
  logic              in_load;
  logic              flush;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_wr, in_load, flush,
    input  in_ready, fwd_rs_sel, fwd_rt_sel, wb_valid, wb_rd, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_wr, in_load, flush,
    output in_ready, fwd_rs_sel, fwd_rt_sel, wb_valid, wb_rd, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_spine_stage_meta.sv
// One in-flight stage's metadata register: shifts in every clock, with a
// synchronous kill of the valid bit.
module pipe_stage_meta
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  stage_meta_t d_i,
  output stage_meta_t q_o
);
  stage_meta_t meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
    end else begin
      meta_q <= d_i;
      if (clr_i) meta_q.v <= 1'b0;
    end
  end

  assign q_o = meta_q;
endmodule

// File: rtl/pipe_hazard_spine.sv
// Pipeline-control spine: tracks per-stage destination metadata and derives
// load-use stalls, operand forwarding selects, flush kills and event counters.
module pipe_hazard_spine
  import pipe_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_spine_if.slave bus
);
  localparam int SEL_W = sel_width(STAGES);

  stage_meta_t           meta_q [STAGES];
  stage_meta_t           meta_d [STAGES];
  logic [STAGES-1:0]     clr;
  logic [REG_AW_MAX-1:0] rs_w, rt_w;
  logic                  rs_found, rs_avail, rt_found, rt_avail;
  logic [SEL_W-1:0]      rs_sel, rt_sel;
  logic                  rs_haz, rt_haz, hazard, issue;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Scan oldest to youngest so the youngest matching writer overwrites the result.
  always_comb begin
    rs_w     = REG_AW_MAX'(bus.in_rs);
    rt_w     = REG_AW_MAX'(bus.in_rt);
    rs_found = 1'b0;
    rs_avail = 1'b0;
    rs_sel   = SEL_W'(SEL_REGFILE);
    rt_found = 1'b0;
    rt_avail = 1'b0;
    rt_sel   = SEL_W'(SEL_REGFILE);
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (writes_reg(meta_q[k], rs_w)) begin
        rs_found = 1'b1;
        rs_avail = result_avail(meta_q[k], k, LOAD_LAT);
        rs_sel   = SEL_W'(k + 1);
      end
      if (writes_reg(meta_q[k], rt_w)) begin
        rt_found = 1'b1;
        rt_avail = result_avail(meta_q[k], k, LOAD_LAT);
        rt_sel   = SEL_W'(k + 1);
      end
    end
  end

  assign rs_haz       = rs_found && !rs_avail;
  assign rt_haz       = rt_found && !rt_avail;
  assign hazard       = bus.in_valid && (rs_haz || rt_haz);
  assign bus.in_ready = !rst && !bus.flush && !hazard;
  assign issue        = bus.in_valid && bus.in_ready;

  assign bus.fwd_rs_sel = (rs_found && rs_avail) ? rs_sel : SEL_W'(SEL_REGFILE);
  assign bus.fwd_rt_sel = (rt_found && rt_avail) ? rt_sel : SEL_W'(SEL_REGFILE);

  // Flush kills what lands in stages 1..FLUSH_DEPTH; stage 0 is a bubble anyway
  // because flush also blocks issue.
  always_comb begin
    meta_d[0] = '0;
    if (issue) begin
      meta_d[0].v  = 1'b1;
      meta_d[0].rd = REG_AW_MAX'(bus.in_rd);
      meta_d[0].wr = bus.in_wr;
      meta_d[0].ld = bus.in_load;
    end
    for (int k = 1; k < STAGES; k++) meta_d[k] = meta_q[k-1];
    for (int k = 0; k < STAGES; k++) clr[k] = bus.flush && (k >= 1) && (k <= FLUSH_DEPTH);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_stage_meta u_meta (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr[k]),
      .d_i   (meta_d[k]),
      .q_o   (meta_q[k])
    );
  end

  assign bus.wb_valid = meta_q[STAGES-1].v && meta_q[STAGES-1].wr;
  assign bus.wb_rd    = meta_q[STAGES-1].rd[REG_AW-1:0];

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard && !bus.flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bus.flush && (flush_cnt_q != '1))            flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_spine.sv
// Directed bench for pipe_hazard_spine (STAGES=3, LOAD_LAT=1, FLUSH_DEPTH=1, CNT_W=4).
module tb_pipe_hazard_spine;
  import pipe_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_hazard_spine_if #(.REG_AW(5), .SEL_W(2), .CNT_W(4)) bus ();

  pipe_hazard_spine #(
    .STAGES(3), .REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_wr = 1'b0; bus.in_load = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle's inputs at the falling edge, then settles before checks.
  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic wr, input logic ld, input logic fl);
    @(negedge clk);
    bus.in_valid = v; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_wr = wr; bus.in_load = ld; bus.flush = fl;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_rs = 5'd3; bus.in_rt = 5'd4; bus.in_rd = 5'd3;
    bus.in_wr = 1'b1; bus.in_load = 1'b0; bus.flush = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", bus.wb_valid); end
    checks++; if (bus.fwd_rs_sel !== 2'd0 || bus.fwd_rt_sel !== 2'd0) begin
      failures++; $display("FAIL reset_sel got=%0d/%0d exp=0/0", bus.fwd_rs_sel, bus.fwd_rt_sel); end
    checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt); end
    @(negedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin
      failures++; $display("FAIL reset_held got=%0b/%0b exp=0/0", bus.in_ready, bus.wb_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_first_issue got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_alu_back_to_back();
    apply_reset();
    set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL alu_issue_ready got=%0b exp=1", bus.in_ready); end
    set_in(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL alu_b2b_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.fwd_rs_sel !== 2'd1) begin failures++; $display("FAIL alu_rs_sel got=%0d exp=1", bus.fwd_rs_sel); end
    set_in(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.fwd_rt_sel !== 2'd2 || bus.fwd_rs_sel !== 2'd0) begin
      failures++; $display("FAIL alu_rt_sel got=%0d/%0d exp=2/0", bus.fwd_rt_sel, bus.fwd_rs_sel); end
    idle();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd3) begin
      failures++; $display("FAIL alu_wb_first got=%0b/%0d exp=1/3", bus.wb_valid, bus.wb_rd); end
    idle();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd4) begin
      failures++; $display("FAIL alu_wb_second got=%0b/%0d exp=1/4", bus.wb_valid, bus.wb_rd); end
    idle();
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL alu_wb_nowrite got=%0b exp=0", bus.wb_valid); end
    checks++; if (bus.stall_cnt !== 4'd0) begin failures++; $display("FAIL alu_no_stall got=%0d exp=0", bus.stall_cnt); end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.fwd_rs_sel !== 2'd0) begin failures++; $display("FAIL lu_stall_sel got=%0d exp=0", bus.fwd_rs_sel); end
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL lu_release_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.fwd_rs_sel !== 2'd2) begin failures++; $display("FAIL lu_release_sel got=%0d exp=2", bus.fwd_rs_sel); end
    checks++; if (bus.stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", bus.stall_cnt); end
    idle();
    checks++; if (bus.stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall_cnt_hold got=%0d exp=1", bus.stall_cnt); end
  endtask

  task automatic test_youngest_wins();
    apply_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.fwd_rs_sel !== 2'd1) begin failures++; $display("FAIL yw_rs_sel got=%0d exp=1", bus.fwd_rs_sel); end
    checks++; if (bus.fwd_rt_sel !== 2'd2) begin failures++; $display("FAIL yw_rt_sel got=%0d exp=2", bus.fwd_rt_sel); end
    apply_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_in(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b1 || bus.fwd_rs_sel !== 2'd0 || bus.fwd_rt_sel !== 2'd0) begin
      failures++; $display("FAIL yw_r0 got=%0b/%0d/%0d exp=1/0/0", bus.in_ready, bus.fwd_rs_sel, bus.fwd_rt_sel); end
    idle();
    checks++; if (bus.stall_cnt !== 4'd0) begin failures++; $display("FAIL yw_r0_stall got=%0d exp=0", bus.stall_cnt); end
  endtask

  task automatic test_flush();
    apply_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fl_ready got=%0b exp=0", bus.in_ready); end
    idle();
    checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd1) begin
      failures++; $display("FAIL fl_counts got=%0d/%0d exp=0/1", bus.stall_cnt, bus.flush_cnt); end
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd9) begin
      failures++; $display("FAIL fl_older_wb got=%0b/%0d exp=1/9", bus.wb_valid, bus.wb_rd); end
    idle();
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL fl_load_killed got=%0b exp=0", bus.wb_valid); end
    idle();
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL fl_issue_blocked got=%0b exp=0", bus.wb_valid); end
  endtask

  // Constant load-with-self-dependence alternates issue / stall every cycle.
  task automatic test_saturation();
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      checks++; if (bus.in_ready !== ((i % 2) == 1)) begin
        failures++; $display("FAIL sat_ready_c%0d got=%0b exp=%0b", i, bus.in_ready, ((i % 2) == 1)); end
      if (i == 21) begin
        checks++; if (bus.stall_cnt !== 4'd10) begin failures++; $display("FAIL sat_mid got=%0d exp=10", bus.stall_cnt); end
      end
    end
    idle();
    checks++; if (bus.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", bus.stall_cnt); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    set_in(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    idle();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd1 || bus.flush_cnt !== 4'd1) begin
      failures++; $display("FAIL ar_pre got=%0b/%0d/%0d exp=1/1/1", bus.wb_valid, bus.wb_rd, bus.flush_cnt); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL ar_immediate got=%0b/%0b exp=0/0", bus.wb_valid, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      failures++; $display("FAIL ar_counters got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL ar_no_wb_c%0d got=%0b exp=0", i, bus.wb_valid); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    bus.in_valid = 1'b0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_wr = 1'b0; bus.in_load = 1'b0; bus.flush = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_youngest_wins();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
